// File: rtl/coin_input_conditioner.sv
// Coin-slot and BUY button front end for the vending FSM. It synchronises and debounces both inputs,
// arbitrates coin/buy collisions, applies the post-buy lockout and keeps a saturating coin tally.

module cic_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   output logic press
);
   // state | meaning
   // IDLE  | settled low, waiting for a rise
   // RISE  | counting stable-high samples before accepting the press
   // HIGH  | settled high, press already reported
   // FALL  | counting stable-low samples before accepting the release

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RISE = 2'd1,
      ST_HIGH = 2'd2,
      ST_FALL = 2'd3
   } state_t;

   localparam logic [7:0] DB_CNT = 8'(DEBOUNCE_CYCLES);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The input must be seen on DEBOUNCE_CYCLES+1 consecutive samples before a level change is accepted
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (s) begin
               state_d = ST_RISE;
               cnt_d   = 8'd1;
            end
         end
         ST_RISE: begin
            if (!s) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q == DB_CNT) begin
               state_d = ST_HIGH;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = ST_FALL;
               cnt_d   = 8'd1;
            end
         end
         ST_FALL: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = 8'd0;
            end else if (cnt_q == DB_CNT) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      press = 1'b0;
      if (state_q == ST_RISE && s && cnt_q == DB_CNT) press = 1'b1;
   end

endmodule

module coin_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_raw,
   input  logic       buy_raw,
   input  logic       clr_count,
   output logic       coin,
   output logic       buy,
   output logic       busy,
   output logic [7:0] coin_count
);

   localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

   logic       coin_meta_q, coin_meta_d;
   logic       coin_sync_q, coin_sync_d;
   logic       buy_meta_q, buy_meta_d;
   logic       buy_sync_q, buy_sync_d;
   logic       coin_q, coin_d;
   logic       buy_q, buy_d;
   logic       pend_q, pend_d;
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic [7:0] count_q, count_d;

   logic coin_ev, buy_ev, buy_ok, locked;

   always_comb begin
      coin_meta_d = coin_raw;
      coin_sync_d = coin_meta_q;
      buy_meta_d  = buy_raw;
      buy_sync_d  = buy_meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_meta_q <= 1'b0;
         coin_sync_q <= 1'b0;
         buy_meta_q  <= 1'b0;
         buy_sync_q  <= 1'b0;
      end else begin
         coin_meta_q <= coin_meta_d;
         coin_sync_q <= coin_sync_d;
         buy_meta_q  <= buy_meta_d;
         buy_sync_q  <= buy_sync_d;
      end
   end

   cic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (coin_sync_q),
      .press (coin_ev)
   );

   cic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_buy (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (buy_sync_q),
      .press (buy_ev)
   );

   assign locked = (lock_cnt_q != 8'd0);

   // A coin always wins the cycle; a colliding buy is parked for one cycle so the two never overlap
   always_comb begin
      buy_ok = buy_ev & ~locked;
      coin_d = coin_ev;
      pend_d = buy_ok & coin_ev;
      buy_d  = (buy_ok & ~coin_ev) | pend_q;
   end

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (buy_q)       lock_cnt_d = LOCK_LOAD;
      else if (locked) lock_cnt_d = lock_cnt_q - 8'd1;
   end

   always_comb begin
      count_d = count_q;
      if (clr_count)                       count_d = {7'd0, coin_q};
      else if (coin_q && count_q != 8'hFF) count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_q     <= 1'b0;
         buy_q      <= 1'b0;
         pend_q     <= 1'b0;
         lock_cnt_q <= 8'd0;
         count_q    <= 8'd0;
      end else begin
         coin_q     <= coin_d;
         buy_q      <= buy_d;
         pend_q     <= pend_d;
         lock_cnt_q <= lock_cnt_d;
         count_q    <= count_d;
      end
   end

   assign coin       = coin_q;
   assign buy        = buy_q;
   assign busy       = locked;
   assign coin_count = count_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
// Pulse positions are counted in clock edges from the edge after a raw input changes.

module tb_coin_input_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_raw;
   logic       buy_raw;
   logic       clr_count;
   logic       coin;
   logic       buy;
   logic       busy;
   logic [7:0] coin_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int cp, cf, bp, bf, yp, yf, both, r;

   coin_input_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .LOCKOUT_CYCLES  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .coin_raw   (coin_raw),
      .buy_raw    (buy_raw),
      .clr_count  (clr_count),
      .coin       (coin),
      .buy        (buy),
      .busy       (busy),
      .coin_count (coin_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

   task automatic clr_acc();
      cp = 0; cf = -1; bp = 0; bf = -1; yp = 0; yf = -1; both = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (coin === 1'b1) begin cp++; if (cf < 0) cf = cyc; end
      if (buy === 1'b1)  begin bp++; if (bf < 0) bf = cyc; end
      if (busy === 1'b1) begin yp++; if (yf < 0) yf = cyc; end
      if (coin === 1'b1 && buy === 1'b1) both++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; coin_raw = 1'b0; buy_raw = 1'b0; clr_count = 1'b0;
      clr_acc();
      repeat (3) tick();
      chk("rst_coin", {31'd0, coin}, 0);
      chk("rst_buy", {31'd0, buy}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_count", {24'd0, coin_count}, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // clean coin press, then release
      clr_acc();
      coin_raw = 1'b1; r = cyc;
      repeat (20) tick();
      chk("t1_coin_pulses", cp, 1);
      chk("t1_coin_edge", cf, r + 7);
      chk("t1_buy_pulses", bp, 0);
      chk("t1_count", {24'd0, coin_count}, 1);
      clr_acc();
      coin_raw = 1'b0;
      repeat (15) tick();
      chk("t1_release_pulses", cp, 0);

      // 3-cycle glitches, then a stable press
      clr_acc();
      for (int g = 0; g < 3; g++) begin
         coin_raw = 1'b1; repeat (3) tick();
         coin_raw = 1'b0; repeat (3) tick();
      end
      chk("t2_glitch_pulses", cp, 0);
      coin_raw = 1'b1; r = cyc;
      repeat (15) tick();
      chk("t2_coin_pulses", cp, 1);
      chk("t2_coin_edge", cf, r + 7);
      coin_raw = 1'b0;
      repeat (12) tick();
      chk("t2_count", {24'd0, coin_count}, 2);

      // clean buy, lockout window, coin accepted while busy
      clr_acc();
      buy_raw = 1'b1; r = cyc;
      repeat (3) tick();
      coin_raw = 1'b1;
      repeat (9) tick();
      buy_raw = 1'b0; coin_raw = 1'b0;
      repeat (15) tick();
      chk("t3_buy_pulses", bp, 1);
      chk("t3_buy_edge", bf, r + 7);
      chk("t3_busy_cycles", yp, 8);
      chk("t3_busy_start", yf, r + 8);
      chk("t3_coin_pulses", cp, 1);
      chk("t3_coin_edge", cf, r + 10);
      chk("t3_count", {24'd0, coin_count}, 3);

      // coin/buy collision, then a second buy whose event lands in the lockout
      clr_acc();
      coin_raw = 1'b1; buy_raw = 1'b1; r = cyc;
      repeat (5) tick();
      buy_raw = 1'b0;
      repeat (5) tick();
      buy_raw = 1'b1;
      repeat (10) tick();
      coin_raw = 1'b0; buy_raw = 1'b0;
      repeat (15) tick();
      chk("t4_coin_edge", cf, r + 7);
      chk("t4_buy_edge", bf, r + 8);
      chk("t4_busy_start", yf, r + 9);
      chk("t4_busy_cycles", yp, 8);
      chk("t4_buy_pulses", bp, 1);
      chk("t4_coin_pulses", cp, 1);
      chk("t4_overlap", both, 0);
      chk("t4_count", {24'd0, coin_count}, 4);

      // clear, saturation, clear colliding with a coin pulse
      clr_count = 1'b1; tick();
      clr_count = 1'b0; tick();
      chk("t5_clear", {24'd0, coin_count}, 0);
      clr_acc();
      for (int i = 1; i <= 257; i++) begin
         coin_raw = 1'b1; repeat (5) tick();
         coin_raw = 1'b0; repeat (5) tick();
         if (i == 254) chk("t5_count_254", {24'd0, coin_count}, 254);
         if (i == 255) chk("t5_count_255", {24'd0, coin_count}, 255);
      end
      chk("t5_pulses", cp, 257);
      chk("t5_saturated", {24'd0, coin_count}, 255);
      coin_raw = 1'b1;
      for (int k = 0; k < 20 && coin !== 1'b1; k++) tick();
      chk("t5_coin_seen", {31'd0, coin}, 1);
      clr_count = 1'b1; tick();
      clr_count = 1'b0;
      chk("t5_clr_with_coin", {24'd0, coin_count}, 1);
      coin_raw = 1'b0;
      repeat (12) tick();
      chk("t5_count_after", {24'd0, coin_count}, 1);

      // reset while busy with buy held, then fresh press after release
      clr_acc();
      buy_raw = 1'b1;
      repeat (10) tick();
      chk("t6_busy_before", {31'd0, busy}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_coin", {31'd0, coin}, 0);
      chk("t6_rst_buy", {31'd0, buy}, 0);
      chk("t6_rst_busy", {31'd0, busy}, 0);
      chk("t6_rst_count", {24'd0, coin_count}, 0);
      repeat (2) tick();
      rst_n = 1'b1; r = cyc;
      clr_acc();
      repeat (20) tick();
      chk("t6_buy_pulses", bp, 1);
      chk("t6_buy_edge", bf, r + 7);
      chk("t6_coin_pulses", cp, 0);
      chk("t6_busy_cycles", yp, 8);
      buy_raw = 1'b0;
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
